// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the data-size bridge FSM state type.
// Shared by ahb_dsize_bridge and anything that decodes its bus.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SINGLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_ERR1,
    ST_ERR2
  } dsz_state_t;

endpackage

// File: rtl/ahb_dsize_bridge.sv
// 64-bit AHB-Lite slave to 32-bit AHB-Lite master; 64-bit reads split into two beats (AHB_DSIZE_ERR_EN enables error relay).
// Latency: single 2 cycles, 64-bit read 3 cycles, +1 per downstream wait state.
// Backpressure: S_HREADYOUT low until the final downstream data phase sees M_HREADY=1.
module ahb_dsize_bridge
  import ahb_pkg::*;
#(
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        S_HSEL,
  input  logic [31:0] S_HADDR,
  input  logic [1:0]  S_HTRANS,
  input  logic [2:0]  S_HSIZE,
  input  logic        S_HWRITE,
  input  logic [31:0] S_HWDATA,
  input  logic        S_HREADY,
  output logic [63:0] S_HRDATA,
  output logic        S_HREADYOUT,
  output logic        S_HRESP,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic [2:0]  M_HSIZE,
  output logic        M_HWRITE,
  output logic [31:0] M_HWDATA,
  input  logic [31:0] M_HRDATA,
  input  logic        M_HREADY,
  input  logic        M_HRESP
);

  dsz_state_t  state_q, state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] lo_q, lo_d;
  logic        lane_q, lane_d;
  logic        accept, done, err_seen, unused_ok;
  logic [31:0] fill;

`ifdef AHB_DSIZE_ERR_EN
  assign err_seen  = M_HRESP;
  assign unused_ok = S_HTRANS[0];
`else
  assign err_seen  = 1'b0;
  assign unused_ok = ^{S_HTRANS[0], M_HRESP};
`endif

  assign accept = S_HSEL & S_HTRANS[1] & S_HREADY;
  assign fill   = ZERO_FILL ? 32'h0 : M_HRDATA;

  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    lo_d        = lo_q;
    lane_d      = lane_q;
    done        = 1'b0;
    S_HREADYOUT = 1'b0;
    S_HRESP     = 1'b0;
    S_HRDATA    = 64'h0;

    // Within SINGLE/BEAT1 a non-IDLE htrans_q means our address phase is still on the bus.
    case (state_q)
      ST_IDLE: S_HREADYOUT = 1'b1;
      ST_SINGLE: begin
        if (htrans_q != HTRANS_IDLE) begin
          hwdata_d = S_HWDATA;
          if (M_HREADY) htrans_d = HTRANS_IDLE;
        end else if (err_seen) begin
          state_d = ST_ERR1;
        end else if (M_HREADY) begin
          done        = 1'b1;
          S_HREADYOUT = 1'b1;
          if (!hwrite_q) S_HRDATA = lane_q ? {M_HRDATA, fill} : {fill, M_HRDATA};
        end
      end
      ST_BEAT0: begin
        if (M_HREADY) begin
          state_d  = ST_BEAT1;
          htrans_d = HTRANS_SEQ;
          haddr_d  = haddr_q + 32'd4;
        end
      end
      ST_BEAT1: begin
        if (err_seen) begin
          state_d  = ST_ERR1;
          htrans_d = HTRANS_IDLE;
        end else if (M_HREADY) begin
          if (htrans_q != HTRANS_IDLE) begin
            lo_d     = M_HRDATA;
            htrans_d = HTRANS_IDLE;
          end else begin
            done        = 1'b1;
            S_HREADYOUT = 1'b1;
            S_HRDATA    = {M_HRDATA, lo_q};
          end
        end
      end
`ifdef AHB_DSIZE_ERR_EN
      ST_ERR1: begin
        S_HRESP = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        S_HREADYOUT = 1'b1;
        S_HRESP     = 1'b1;
        state_d     = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (done) state_d = ST_IDLE;

    if ((state_q == ST_IDLE || done) && accept) begin
      haddr_d  = S_HADDR;
      hsize_d  = S_HSIZE;
      hwrite_d = S_HWRITE;
      lane_d   = S_HADDR[2];
      htrans_d = HTRANS_NONSEQ;
      state_d  = ST_SINGLE;
      if (!S_HWRITE && S_HSIZE == HSIZE_DWORD) begin
        state_d = ST_BEAT0;
        haddr_d = {S_HADDR[31:3], 3'b000};
        hsize_d = HSIZE_WORD;
      end else if (S_HWRITE && S_HSIZE == HSIZE_DWORD) begin
`ifdef AHB_DSIZE_ERR_EN
        state_d  = ST_ERR1;
        htrans_d = HTRANS_IDLE;
`else
        hsize_d  = HSIZE_WORD;
`endif
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= 32'h0;
      hsize_q  <= 3'd0;
      hwrite_q <= 1'b0;
      hwdata_q <= 32'h0;
      lo_q     <= 32'h0;
      lane_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      lo_q     <= lo_d;
      lane_q   <= lane_d;
    end
  end

  assign M_HADDR  = haddr_q;
  assign M_HTRANS = htrans_q;
  assign M_HSIZE  = hsize_q;
  assign M_HWRITE = hwrite_q;
  assign M_HWDATA = hwdata_q;

endmodule

// File: tb/tb_ahb_dsize_bridge.sv
// Directed bench for ahb_dsize_bridge: table of transfers against a behavioural 32-bit slave,
// plus back-to-back, reset-mid-transfer and address-hold sequences.
module tb_ahb_dsize_bridge;

  localparam logic [31:0] NONE = 32'hFFFF_FFF0;
  localparam int NV = 10;

  logic        HCLK, HRESETn;
  logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT, S_HRESP;
  logic [31:0] S_HADDR, S_HWDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;
  logic [63:0] S_HRDATA, rdata_z0;
  logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
  logic [1:0]  M_HTRANS;
  logic [2:0]  M_HSIZE;
  logic        M_HWRITE, M_HREADY, M_HRESP;
  logic        unused_z0_rdy, unused_z0_resp, unused_z0_hwrite;
  logic [31:0] unused_z0_haddr, unused_z0_hwdata;
  logic [1:0]  unused_z0_htrans;
  logic [2:0]  unused_z0_hsize;

  assign S_HREADY = S_HREADYOUT;

  ahb_dsize_bridge u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE),
    .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HSIZE(M_HSIZE), .M_HWRITE(M_HWRITE),
    .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP)
  );

  ahb_dsize_bridge #(.ZERO_FILL(1'b0)) u_dut_zf0 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE),
    .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HRDATA(rdata_z0), .S_HREADYOUT(unused_z0_rdy), .S_HRESP(unused_z0_resp),
    .M_HADDR(unused_z0_haddr), .M_HTRANS(unused_z0_htrans), .M_HSIZE(unused_z0_hsize),
    .M_HWRITE(unused_z0_hwrite), .M_HWDATA(unused_z0_hwdata),
    .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h1000: mem_rd = 32'hAAAA_0001;
      32'h1004: mem_rd = 32'hBBBB_0002;
      default:  mem_rd = {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Behavioural downstream slave with per-address wait states and a two-cycle error response.
  logic [31:0] wait_addr, err_addr, dph_addr;
  int          wait_n, wcnt;
  logic        dph_vld, dph_wr;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_vld <= 1'b0; dph_addr <= 32'h0; dph_wr <= 1'b0; wcnt <= 0;
    end else if (M_HREADY) begin
      dph_vld  <= M_HTRANS[1];
      dph_addr <= M_HADDR;
      dph_wr   <= M_HWRITE;
      wcnt     <= (M_HTRANS[1] && M_HADDR == wait_addr) ? wait_n :
                  (M_HTRANS[1] && M_HADDR == err_addr) ? 1 : 0;
    end else begin
      wcnt <= wcnt - 1;
    end
  end

  assign M_HREADY = !dph_vld || (wcnt == 0);
  assign M_HRESP  = dph_vld && (dph_addr == err_addr);
  assign M_HRDATA = dph_vld ? mem_rd(dph_addr) : 32'h0;

  logic [31:0] aq_addr[$];
  logic [1:0]  aq_trans[$];
  logic [2:0]  aq_size[$];
  int          aq_cyc[$];
  int          cyc_cnt = 0;
  int          wr_cyc;
  logic [31:0] wr_data;
  logic        wr_seen;

  always @(posedge HCLK) begin
    cyc_cnt++;
    if (HRESETn && M_HREADY && M_HTRANS[1]) begin
      aq_addr.push_back(M_HADDR);
      aq_trans.push_back(M_HTRANS);
      aq_size.push_back(M_HSIZE);
      aq_cyc.push_back(cyc_cnt);
    end
    if (HRESETn && dph_vld && M_HREADY && dph_wr) begin
      wr_seen = 1'b1;
      wr_data = M_HWDATA;
      wr_cyc  = cyc_cnt;
    end
  end

  // Downstream address/transfer must not move while the slave stalls (error cancel excepted).
  logic        prev_stall = 1'b0;
  logic [33:0] prev_ap;
  always @(negedge HCLK) begin
    if (HRESETn && prev_stall) chk("addr_hold", 64'({M_HTRANS, M_HADDR}), 64'(prev_ap));
    prev_stall = HRESETn && !M_HREADY && !M_HRESP;
    prev_ap    = {M_HTRANS, M_HADDR};
  end

  task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic [31:0] wd, output int cyc, output logic resp_any);
    @(negedge HCLK);
    S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = a; S_HSIZE = sz; S_HWRITE = wr;
    @(negedge HCLK);
    S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWDATA = wd;
    cyc = 1;
    resp_any = S_HRESP;
    while (!S_HREADYOUT && cyc < 40) begin
      @(negedge HCLK);
      cyc++;
      resp_any = resp_any | S_HRESP;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] wait_addr;
    int          wait_n;
    logic [31:0] err_addr;
    int          exp_cyc;
    logic        chk_rd;
    logic [63:0] exp_rd;
    logic [63:0] exp_rd0;
    int          exp_naddr;
    logic [31:0] exp_a0;
    logic [2:0]  exp_s0;
    logic        exp_resp;
  } vec_t;

  function automatic vec_t mkv(logic [31:0] addr, logic [2:0] size, logic wr, logic [31:0] wdata,
                               logic [31:0] wa, int wn, logic [31:0] ea, int cyc, logic crd,
                               logic [63:0] rd, logic [63:0] rd0, int na, logic [31:0] a0,
                               logic [2:0] s0, logic resp);
    vec_t v;
    v.addr = addr; v.size = size; v.wr = wr; v.wdata = wdata;
    v.wait_addr = wa; v.wait_n = wn; v.err_addr = ea;
    v.exp_cyc = cyc; v.chk_rd = crd; v.exp_rd = rd; v.exp_rd0 = rd0;
    v.exp_naddr = na; v.exp_a0 = a0; v.exp_s0 = s0; v.exp_resp = resp;
    return v;
  endfunction

  vec_t        vecs[NV];
  vec_t        v;
  int          cyc;
  logic        resp_any;
  logic [31:0] a0;
  logic [1:0]  t0;
  logic [2:0]  s0;
  int          c0;

  initial begin
    vecs[0] = mkv(32'h1000, 3'd3, 0, 0, NONE, 0, NONE, 3, 1, 64'hBBBB0002_AAAA0001, 64'hBBBB0002_AAAA0001, 2, 32'h1000, 3'd2, 0);
    vecs[1] = mkv(32'h2004, 3'd2, 0, 0, NONE, 0, NONE, 2, 1, 64'h2004DFFB_00000000, 64'h2004DFFB_2004DFFB, 1, 32'h2004, 3'd2, 0);
    vecs[2] = mkv(32'h2000, 3'd2, 0, 0, NONE, 0, NONE, 2, 1, 64'h00000000_2000DFFF, 64'h2000DFFF_2000DFFF, 1, 32'h2000, 3'd2, 0);
    vecs[3] = mkv(32'h3003, 3'd0, 1, 32'h5A00_0000, NONE, 0, NONE, 2, 0, 64'h0, 64'h0, 1, 32'h3003, 3'd0, 0);
    vecs[4] = mkv(32'h1006, 3'd3, 0, 0, NONE, 0, NONE, 3, 1, 64'hBBBB0002_AAAA0001, 64'hBBBB0002_AAAA0001, 2, 32'h1000, 3'd2, 0);
    vecs[5] = mkv(32'h5000, 3'd3, 0, 0, 32'h5004, 2, NONE, 5, 1, 64'h5004AFFB_5000AFFF, 64'h5004AFFB_5000AFFF, 2, 32'h5000, 3'd2, 0);
    vecs[6] = mkv(32'h4000, 3'd3, 0, 0, 32'h4000, 1, NONE, 4, 1, 64'h4004BFFB_4000BFFF, 64'h4004BFFB_4000BFFF, 2, 32'h4000, 3'd2, 0);
    vecs[7] = mkv(32'h6002, 3'd1, 0, 0, 32'h6002, 1, NONE, 3, 1, 64'h00000000_60029FFD, 64'h60029FFD_60029FFD, 1, 32'h6002, 3'd1, 0);
`ifdef AHB_DSIZE_ERR_EN
    vecs[8] = mkv(32'h7000, 3'd3, 1, 32'h1234_5678, NONE, 0, NONE, 2, 0, 64'h0, 64'h0, 0, 32'h0, 3'd0, 1);
    vecs[9] = mkv(32'h8000, 3'd3, 0, 0, NONE, 0, 32'h8000, 4, 0, 64'h0, 64'h0, 1, 32'h8000, 3'd2, 1);
`else
    vecs[8] = mkv(32'h7000, 3'd3, 1, 32'h1234_5678, NONE, 0, NONE, 2, 0, 64'h0, 64'h0, 1, 32'h7000, 3'd2, 0);
    vecs[9] = mkv(32'h8000, 3'd3, 0, 0, NONE, 0, 32'h8000, 4, 1, 64'h80047FFB_80007FFF, 64'h80047FFB_80007FFF, 2, 32'h8000, 3'd2, 0);
`endif

    HRESETn = 1'b0;
    S_HSEL = 0; S_HADDR = 0; S_HTRANS = 0; S_HSIZE = 0; S_HWRITE = 0; S_HWDATA = 0;
    wait_addr = NONE; wait_n = 0; err_addr = NONE; wr_seen = 0; wr_data = 0; wr_cyc = 0;
    #2;
    chk("rst_s_side", 64'({S_HREADYOUT, S_HRESP}), 64'(2'b10));
    chk("rst_s_hrdata", S_HRDATA, 64'h0);
    chk("rst_m_ctrl", 64'({M_HTRANS, M_HSIZE, M_HWRITE}), 64'h0);
    chk("rst_m_haddr", 64'(M_HADDR), 64'h0);
    chk("rst_m_hwdata", 64'(M_HWDATA), 64'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      wait_addr = v.wait_addr; wait_n = v.wait_n; err_addr = v.err_addr;
      aq_addr.delete(); aq_trans.delete(); aq_size.delete(); aq_cyc.delete();
      wr_seen = 1'b0;
      xfer(v.addr, v.size, v.wr, v.wdata, cyc, resp_any);
      chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(v.exp_cyc));
      chk($sformatf("v%0d_hresp", i), 64'(S_HRESP), 64'(v.exp_resp));
      chk($sformatf("v%0d_hresp_any", i), 64'(resp_any), 64'(v.exp_resp));
      if (v.chk_rd) begin
        chk($sformatf("v%0d_rdata_zf1", i), S_HRDATA, v.exp_rd);
        chk($sformatf("v%0d_rdata_zf0", i), rdata_z0, v.exp_rd0);
      end
      repeat (2) @(negedge HCLK);
      chk($sformatf("v%0d_n_addr_phases", i), 64'(aq_addr.size()), 64'(v.exp_naddr));
      if (v.exp_naddr > 0) begin
        a0 = (aq_addr.size() > 0) ? aq_addr[0] : 32'hDEAD_BEEF;
        t0 = (aq_trans.size() > 0) ? aq_trans[0] : 2'b00;
        s0 = (aq_size.size() > 0) ? aq_size[0] : 3'b111;
        c0 = (aq_cyc.size() > 0) ? aq_cyc[0] : -100;
        chk($sformatf("v%0d_haddr0", i), 64'(a0), 64'(v.exp_a0));
        chk($sformatf("v%0d_htrans0", i), 64'(t0), 64'(2'b10));
        chk($sformatf("v%0d_hsize0", i), 64'(s0), 64'(v.exp_s0));
        if (v.wr) begin
          chk($sformatf("v%0d_wr_seen", i), 64'(wr_seen), 64'h1);
          chk($sformatf("v%0d_hwdata", i), 64'(wr_data), 64'(v.wdata));
          chk($sformatf("v%0d_wr_timing", i), 64'(wr_cyc - c0), 64'h1);
        end
      end
    end

    // Back-to-back: second read presented in the completing cycle of the first.
    wait_addr = NONE; err_addr = NONE;
    aq_addr.delete(); aq_trans.delete(); aq_size.delete(); aq_cyc.delete();
    xfer(32'h1000, 3'd3, 1'b0, 32'h0, cyc, resp_any);
    chk("b2b_first_cycles", 64'(cyc), 64'd3);
    chk("b2b_first_rdata", S_HRDATA, 64'hBBBB0002_AAAA0001);
    S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 32'h2004; S_HSIZE = 3'd2; S_HWRITE = 1'b0;
    @(negedge HCLK);
    S_HSEL = 1'b0; S_HTRANS = 2'b00;
    chk("b2b_captured", 64'(S_HREADYOUT), 64'h0);
    cyc = 1;
    while (!S_HREADYOUT && cyc < 40) begin
      @(negedge HCLK);
      cyc++;
    end
    chk("b2b_second_cycles", 64'(cyc), 64'd2);
    chk("b2b_second_rdata", S_HRDATA, 64'h2004DFFB_00000000);
    repeat (2) @(negedge HCLK);
    chk("b2b_n_addr_phases", 64'(aq_addr.size()), 64'd3);

    // Reset asserted while beat1 is on the bus.
    aq_addr.delete(); aq_trans.delete(); aq_size.delete(); aq_cyc.delete();
    @(negedge HCLK);
    S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 32'h1000; S_HSIZE = 3'd3; S_HWRITE = 1'b0;
    @(negedge HCLK);
    S_HSEL = 1'b0; S_HTRANS = 2'b00;
    @(negedge HCLK);
    chk("mid_beat1_seq", 64'({M_HTRANS, M_HADDR}), 64'({2'b11, 32'h1004}));
    HRESETn = 1'b0;
    #1;
    chk("midrst_s_side", 64'({S_HREADYOUT, S_HRESP}), 64'(2'b10));
    chk("midrst_s_hrdata", S_HRDATA, 64'h0);
    chk("midrst_m_ctrl", 64'({M_HTRANS, M_HSIZE, M_HWRITE}), 64'h0);
    chk("midrst_m_haddr", 64'(M_HADDR), 64'h0);
    chk("midrst_m_hwdata", 64'(M_HWDATA), 64'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    aq_addr.delete(); aq_trans.delete(); aq_size.delete(); aq_cyc.delete();
    repeat (3) @(negedge HCLK);
    chk("post_rst_no_beat", 64'(aq_addr.size()), 64'h0);
    xfer(32'h1000, 3'd3, 1'b0, 32'h0, cyc, resp_any);
    chk("post_rst_cycles", 64'(cyc), 64'd3);
    chk("post_rst_rdata", S_HRDATA, 64'hBBBB0002_AAAA0001);
    repeat (2) @(negedge HCLK);
    chk("post_rst_n_addr", 64'(aq_addr.size()), 64'd2);
    if (aq_addr.size() == 2) begin
      chk("post_rst_ap0", 64'({aq_trans[0], aq_addr[0]}), 64'({2'b10, 32'h1000}));
      chk("post_rst_ap1", 64'({aq_trans[1], aq_addr[1]}), 64'({2'b11, 32'h1004}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_dsize_bridge.md
AHB_DSIZE_BRIDGE -- requirements
Module: ahb_dsize_bridge

Interface
REQ-001 Parameter: ZERO_FILL, default 1; 1 zero-fills the unused 32-bit S_HRDATA lane on single-beat reads, 0 replicates the word into both lanes.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Clock port is HCLK; reset port is HRESETn.
REQ-003 HCLK  in  1  system clock.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 Upstream AHB-Lite slave port, fed by the core instruction master:
- S_HSEL  in  1  select.
- S_HADDR  in  32  address.
- S_HTRANS  in  2  transfer type.
- S_HSIZE  in  3  size.
- S_HWRITE  in  1  write.
- S_HWDATA  in  32  write data.
- S_HREADY  in  1  bus ready.
- S_HRDATA  out  64  read data.
- S_HREADYOUT  out  1  slave ready.
- S_HRESP  out  1  error response.
REQ-006 Downstream 32-bit AHB-Lite master port:
- M_HADDR  out  32.
- M_HTRANS  out  2.
- M_HSIZE  out  3.
- M_HWRITE  out  1.
- M_HWDATA  out  32.
- M_HRDATA  in  32.
- M_HREADY  in  1.
- M_HRESP  in  1.

Function
REQ-007 Accept: an upstream transfer SHALL be captured when S_HSEL & S_HTRANS[1] & S_HREADY are all high in IDLE; BUSY/IDLE transfers get a zero-wait OKAY response.
REQ-008 FSM states: IDLE, SINGLE, BEAT0, BEAT1, ERR1, ERR2.
- IDLE->BEAT0 on a captured read with HSIZE=3.
- IDLE->SINGLE on any other captured transfer.
REQ-009 Address phases: every downstream address phase SHALL be issued the cycle after capture, from registered values.
- SINGLE: M_HTRANS=NONSEQ, size as captured.
- BEAT0: M_HADDR={addr[31:3],3'b000}, M_HSIZE=2, NONSEQ.
- BEAT1: address +4, SEQ, issued in BEAT0's data phase.
REQ-010 Downstream address phase SHALL hold stable while M_HREADY=0; M_HTRANS=IDLE whenever no beat is pending.
REQ-011 Write data: S_HWDATA SHALL be registered in the upstream data phase and driven on M_HWDATA in the downstream data phase.
REQ-012 64-bit reads: beat0 data is stored to S_HRDATA[31:0] and beat1 to [63:32]; S_HRDATA is valid when S_HREADYOUT rises.
REQ-013 Single-beat reads: the word SHALL be placed in lane addr[2]; the other lane is filled per ZERO_FILL.
REQ-014 Wait states: S_HREADYOUT SHALL be 0 from the cycle after capture until the final downstream data phase completes (M_HREADY=1), then 1 for exactly one cycle.
REQ-015 Latency with a zero-wait downstream: single transfer 2 cycles; 64-bit read 3 cycles (address phase to S_HREADYOUT=1).
REQ-016 Each downstream wait state SHALL add exactly one cycle to upstream latency.
REQ-017 Back-to-back: a new transfer presented in the completing cycle SHALL be captured in that cycle.
REQ-018 Misaligned 64-bit address (addr[2:0]!=0) SHALL be aligned down; no error is raised.

Reset
REQ-019 On HRESETn low, asynchronously:
- FSM=IDLE.
- S_HREADYOUT=1, S_HRESP=0, S_HRDATA=0.
- M_HTRANS=IDLE, M_HADDR=0, M_HSIZE=0, M_HWRITE=0, M_HWDATA=0.
REQ-020 Reset mid-transfer SHALL abandon the transfer with no downstream beat issued after release until a new capture.

Configuration
REQ-021 Macro AHB_DSIZE_ERR_EN defined, M_HRESP honoured:
- An error in any data phase SHALL drive ERR1 (S_HREADYOUT=0, S_HRESP=1), then ERR2 (S_HREADYOUT=1, S_HRESP=1), then IDLE.
- A pending BEAT1 SHALL be cancelled by driving M_HTRANS=IDLE in the cycle after the error is seen.
- A 64-bit write SHALL get the two-cycle error with no downstream beat.
REQ-022 Macro AHB_DSIZE_ERR_EN undefined:
- M_HRESP is ignored and S_HRESP is tied 0.
- ERR states are not built.
- A 64-bit write is issued as a 32-bit write.

Structure
REQ-023 Shared package ahb_pkg SHALL hold the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), the HSIZE encodings and the FSM state typedef.
REQ-024 The design is a single module with no sub-module.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- V1: 64-bit read at 0x1000, memory 0x1000=0xAAAA0001, 0x1004=0xBBBB0002, zero-wait -> S_HRDATA=0xBBBB0002_AAAA0001 on the 3rd cycle; M_HADDR sequence 0x1000 NONSEQ, 0x1004 SEQ.
- V2: 32-bit read at 0x2004 with ZERO_FILL=1 -> S_HRDATA=0x{word}_00000000 after 2 cycles; with ZERO_FILL=0 -> word in both lanes.
- V3: byte write 0x5A to 0x3003 -> M_HSIZE=0, M_HADDR=0x3003, M_HWDATA=S_HWDATA one cycle after the address phase.
- V4: 64-bit read with 2 downstream wait states on beat1 -> completes in 5 cycles; M_HADDR held stable during the waits.
- V5 (ERR_EN): M_HRESP=1 on beat0 -> S_HRESP high for 2 cycles with S_HREADYOUT 0 then 1; M_HTRANS=IDLE next cycle; no beat1 data phase.
- V6: assert HRESETn low during BEAT1 -> all outputs at reset values immediately; next read after release behaves as V1.
